// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer for an RV32I-style core.
// Walks FETCH/DECODE/EXEC/MEM/WB, raises traps and counts retired instructions.
module core_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic        reg_wr_en,
    output logic        pc_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_SYSTEM  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam logic [7:0] TIMEOUT_LIMIT = MEM_TIMEOUT[7:0];

    // Opcodes the sequencer knows how to carry through EXEC.
    function automatic logic is_exec_opcode(input logic [6:0] op);
        logic legal;
        case (op)
            OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE,
            OP_REG, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t      state_r;
    logic [7:0]  wait_r;
    logic [1:0]  cause_r;
    logic [31:0] retired_r;

    assign state      = state_r;
    assign halted     = (state_r == ST_TRAP);
    assign trap_cause = cause_r;
    assign retired    = retired_r;

    // Strobes decoded from current state, opcode and the memory handshakes.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        reg_wr_en = 1'b0;
        pc_sel    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_wr    = imem_ready;
            end
            ST_EXEC: begin
                if (opcode == OP_BRANCH) begin
                    pc_wr  = 1'b1;
                    pc_sel = branch_taken;
                end else if (opcode == OP_FENCE) begin
                    pc_wr  = 1'b1;
                    pc_sel = 1'b0;
                end else begin
                    pc_wr  = 1'b0;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_ready && (opcode == OP_STORE)) begin
                    pc_wr = 1'b1;
                end else begin
                    pc_wr = 1'b0;
                end
            end
            ST_WB: begin
                reg_wr_en = 1'b1;
                pc_wr     = 1'b1;
                pc_sel    = (opcode == OP_JAL) || (opcode == OP_JALR);
            end
            default: begin
                pc_wr = 1'b0;
            end
        endcase
    end

    // Sequencer state, memory wait counter, trap cause and retire counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_FETCH;
            wait_r    <= 8'd0;
            cause_r   <= CAUSE_NONE;
            retired_r <= 32'd0;
        end else begin
            if (pc_wr) begin
                retired_r <= retired_r + 32'd1;
            end
            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_r <= ST_DECODE;
                        wait_r  <= 8'd0;
                    end else if (wait_r == TIMEOUT_LIMIT) begin
                        state_r <= ST_TRAP;
                        cause_r <= CAUSE_TIMEOUT;
                    end else begin
                        wait_r  <= wait_r + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if (is_exec_opcode(opcode)) begin
                        state_r <= ST_EXEC;
                    end else if (opcode == OP_SYSTEM) begin
                        state_r <= ST_TRAP;
                        cause_r <= CAUSE_SYSTEM;
                    end else begin
                        state_r <= ST_TRAP;
                        cause_r <= CAUSE_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: begin
                            state_r <= ST_MEM;
                            wait_r  <= 8'd0;
                        end
                        OP_BRANCH, OP_FENCE: begin
                            state_r <= ST_FETCH;
                            wait_r  <= 8'd0;
                        end
                        default: begin
                            state_r <= ST_WB;
                        end
                    endcase
                end
                ST_MEM: begin
                    // Ready on the final allowed cycle still completes the access.
                    if (dmem_ready) begin
                        wait_r <= 8'd0;
                        if (opcode == OP_STORE) begin
                            state_r <= ST_FETCH;
                        end else begin
                            state_r <= ST_WB;
                        end
                    end else if (wait_r == TIMEOUT_LIMIT) begin
                        state_r <= ST_TRAP;
                        cause_r <= CAUSE_TIMEOUT;
                    end else begin
                        wait_r  <= wait_r + 8'd1;
                    end
                end
                ST_WB: begin
                    state_r <= ST_FETCH;
                    wait_r  <= 8'd0;
                end
                ST_TRAP: begin
                    state_r <= ST_TRAP;
                end
                default: begin
                    state_r <= ST_TRAP;
                    cause_r <= CAUSE_ILLEGAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: instruction classes, traps, timeout and reset.
module tb_core_sequencer;

    logic        clk;
    logic        reset_n;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_wr;
    logic        pc_wr;
    logic        reg_wr_en;
    logic        pc_sel;
    logic [2:0]  state;
    logic        halted;
    logic [1:0]  trap_cause;
    logic [31:0] retired;

    int vectors = 0;
    int miscompares = 0;

    core_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_wr(ir_wr), .pc_wr(pc_wr),
        .reg_wr_en(reg_wr_en), .pc_sel(pc_sel), .state(state), .halted(halted),
        .trap_cause(trap_cause), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        tick(); tick();
        reset_n = 1'b1; #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        chk("rst_ir_wr", 32'(ir_wr), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);

        // ADD with zero-wait memory: 0,1,2,4,0
        opcode = 7'b0110011; imem_ready = 1'b1; dmem_ready = 1'b1; #1;
        chk("add_fetch_ir_wr", 32'(ir_wr), 32'd1);
        tick(); chk("add_decode", 32'(state), 32'd1); chk("add_decode_imem_req", 32'(imem_req), 32'd0);
        tick(); chk("add_exec", 32'(state), 32'd2); chk("add_exec_pc_wr", 32'(pc_wr), 32'd0);
        tick(); chk("add_wb", 32'(state), 32'd4);
        chk("add_wb_reg_wr", 32'(reg_wr_en), 32'd1);
        chk("add_wb_pc_wr", 32'(pc_wr), 32'd1);
        chk("add_wb_pc_sel", 32'(pc_sel), 32'd0);
        tick(); chk("add_back_fetch", 32'(state), 32'd0); chk("add_retired", retired, 32'd1);

        // LW with dmem_ready on the third MEM cycle
        opcode = 7'b0000011; dmem_ready = 1'b0;
        tick(); tick();
        tick(); chk("lw_mem1", 32'(state), 32'd3);
        chk("lw_mem1_req", 32'(dmem_req), 32'd1); chk("lw_mem1_we", 32'(dmem_we), 32'd0);
        tick(); chk("lw_mem2", 32'(state), 32'd3);
        tick(); dmem_ready = 1'b1; #1;
        chk("lw_mem3", 32'(state), 32'd3); chk("lw_mem3_req", 32'(dmem_req), 32'd1);
        chk("lw_mem3_pc_wr", 32'(pc_wr), 32'd0);
        tick(); chk("lw_wb", 32'(state), 32'd4);
        chk("lw_wb_reg_wr", 32'(reg_wr_en), 32'd1); chk("lw_wb_dmem_req", 32'(dmem_req), 32'd0);
        tick(); chk("lw_fetch", 32'(state), 32'd0); chk("lw_retired", retired, 32'd2);
        dmem_ready = 1'b0;

        // BEQ taken, then not taken
        opcode = 7'b1100011; branch_taken = 1'b1;
        tick(); tick();
        chk("beq_t_pc_wr", 32'(pc_wr), 32'd1); chk("beq_t_pc_sel", 32'(pc_sel), 32'd1);
        chk("beq_t_reg_wr", 32'(reg_wr_en), 32'd0);
        tick(); chk("beq_t_fetch", 32'(state), 32'd0); chk("beq_t_retired", retired, 32'd3);
        branch_taken = 1'b0;
        tick(); tick();
        chk("beq_n_pc_wr", 32'(pc_wr), 32'd1); chk("beq_n_pc_sel", 32'(pc_sel), 32'd0);
        tick(); chk("beq_n_retired", retired, 32'd4);

        // JAL selects target in WB
        opcode = 7'b1101111;
        tick(); tick(); chk("jal_exec_pc_wr", 32'(pc_wr), 32'd0);
        tick(); chk("jal_wb_pc_sel", 32'(pc_sel), 32'd1); chk("jal_wb_reg_wr", 32'(reg_wr_en), 32'd1);
        tick(); chk("jal_retired", retired, 32'd5);

        // SW with zero-wait memory
        opcode = 7'b0100011; dmem_ready = 1'b1;
        tick(); tick(); tick();
        chk("sw_mem", 32'(state), 32'd3); chk("sw_we", 32'(dmem_we), 32'd1);
        chk("sw_pc_wr", 32'(pc_wr), 32'd1); chk("sw_pc_sel", 32'(pc_sel), 32'd0);
        chk("sw_reg_wr", 32'(reg_wr_en), 32'd0);
        tick(); chk("sw_fetch", 32'(state), 32'd0); chk("sw_retired", retired, 32'd6);
        dmem_ready = 1'b0;

        // FENCE
        opcode = 7'b0001111;
        tick(); tick(); chk("fence_pc_wr", 32'(pc_wr), 32'd1); chk("fence_pc_sel", 32'(pc_sel), 32'd0);
        tick(); chk("fence_retired", retired, 32'd7);

        // Illegal opcode traps with cause 1
        opcode = 7'b1111111;
        tick(); chk("ill_decode", 32'(state), 32'd1);
        tick(); chk("ill_trap", 32'(state), 32'd5); chk("ill_cause", 32'(trap_cause), 32'd1);
        chk("ill_halted", 32'(halted), 32'd1); chk("ill_retired", retired, 32'd7);
        chk("ill_imem_req", 32'(imem_req), 32'd0);
        tick(); chk("ill_hold", 32'(state), 32'd5); chk("ill_hold_pc_wr", 32'(pc_wr), 32'd0);

        // Reset exits TRAP
        reset_n = 1'b0; tick(); reset_n = 1'b1; imem_ready = 1'b0; #1;
        chk("trst_state", 32'(state), 32'd0); chk("trst_cause", 32'(trap_cause), 32'd0);
        chk("trst_halted", 32'(halted), 32'd0); chk("trst_retired", retired, 32'd0);
        chk("trst_imem_req", 32'(imem_req), 32'd1); chk("trst_pc_wr", 32'(pc_wr), 32'd0);

        // ECALL traps with cause 2
        imem_ready = 1'b1; opcode = 7'b1110011;
        tick(); tick();
        chk("ecall_trap", 32'(state), 32'd5); chk("ecall_cause", 32'(trap_cause), 32'd2);
        chk("ecall_halted", 32'(halted), 32'd1);

        // Reset during a LW memory wait
        reset_n = 1'b0; tick(); reset_n = 1'b1; opcode = 7'b0110011;
        tick(); tick(); tick(); tick(); chk("mrst_add_retired", retired, 32'd1);
        opcode = 7'b0000011;
        tick(); tick(); tick(); tick();
        chk("mrst_in_mem", 32'(state), 32'd3); chk("mrst_mem_req", 32'(dmem_req), 32'd1);
        reset_n = 1'b0; tick(); reset_n = 1'b1; imem_ready = 1'b0; #1;
        chk("mrst_state", 32'(state), 32'd0); chk("mrst_retired", retired, 32'd0);
        chk("mrst_dmem_req", 32'(dmem_req), 32'd0); chk("mrst_imem_req", 32'(imem_req), 32'd1);

        // SW with dmem_ready held low: five MEM cycles then timeout trap
        imem_ready = 1'b1; opcode = 7'b0100011;
        tick(); tick();
        tick(); chk("to_mem0", 32'(state), 32'd3); chk("to_we0", 32'(dmem_we), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_mem%0d", i), 32'(state), 32'd3);
            chk($sformatf("to_we%0d", i), 32'(dmem_we), 32'd1);
        end
        tick(); chk("to_trap", 32'(state), 32'd5); chk("to_cause", 32'(trap_cause), 32'd3);
        chk("to_halted", 32'(halted), 32'd1); chk("to_dmem_req", 32'(dmem_req), 32'd0);
        chk("to_retired", retired, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
